// File: rtl/fifo_axis_reader_if.sv
// AXI-Stream bundle carrying the drained FIFO words downstream.
interface fifo_axis_reader_if #(
    parameter int DATA_WIDTH = 512
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/fifo_axis_reader.sv
// FIFO read-side drain engine: pops head words into an AXI-Stream master, cut into fixed-length frames.
// Optional beat/frame statistics counters are built when FIFO_AXIS_READER_STATS_EN is defined.
module fifo_axis_reader #(
    parameter int DATA_WIDTH  = 512,
    parameter int FRAME_BEATS = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    fifo_axis_reader_if.master    m_axis,
    output logic                  busy,
    output logic [31:0]           stat_frames,
    output logic [31:0]           stat_beats
);

    localparam int CNT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        pop_cnt_reg, pop_cnt_next;
    logic [DATA_WIDTH-1:0]   tdata_reg;
    logic                    tvalid_reg;
    logic                    tlast_reg;
    logic                    pop;
    logic                    accept;
    logic                    frame_popped_complete;

    // In DRAIN, a held tlast beat means the whole frame is already out of the FIFO.
    always_comb begin
        accept                = tvalid_reg && m_axis.tready;
        frame_popped_complete = (state_reg == ST_DRAIN) && tvalid_reg && tlast_reg;
        pop                   = rd_rst_n && (state_reg != ST_IDLE) && !fifo_empty &&
                                (!tvalid_reg || m_axis.tready) && !frame_popped_complete;

        state_next   = state_reg;
        pop_cnt_next = pop_cnt_reg;
        if (pop) begin
            pop_cnt_next = (pop_cnt_reg == LAST_CNT) ? '0 : pop_cnt_reg + CNT_W'(1);
        end

        case (state_reg)
            ST_IDLE: begin
                if (enable) begin
                    state_next   = ST_RUN;
                    pop_cnt_next = '0;
                end
            end
            ST_RUN: begin
                // A pop on the stopping edge starts a frame, so it must be finished.
                if (!enable) begin
                    if ((pop_cnt_reg == '0) && !tvalid_reg && !pop) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && tlast_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            state_reg   <= ST_IDLE;
            pop_cnt_reg <= '0;
            tdata_reg   <= '0;
            tvalid_reg  <= 1'b0;
            tlast_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pop_cnt_reg <= pop_cnt_next;
            if (pop) begin
                tdata_reg  <= fifo_data;
                tvalid_reg <= 1'b1;
                tlast_reg  <= (pop_cnt_reg == LAST_CNT);
            end else if (accept) begin
                tvalid_reg <= 1'b0;
            end
        end
    end

    assign fifo_rd_en    = pop;
    assign m_axis.tdata  = tdata_reg;
    assign m_axis.tvalid = tvalid_reg;
    assign m_axis.tlast  = tlast_reg;
    assign busy          = (state_reg != ST_IDLE) || tvalid_reg;

    generate
        for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_keep
            assign m_axis.tkeep[gi] = 1'b1;
        end
    endgenerate

`ifdef FIFO_AXIS_READER_STATS_EN
    logic [31:0] stat_frames_reg;
    logic [31:0] stat_beats_reg;

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            stat_frames_reg <= '0;
            stat_beats_reg  <= '0;
        end else if (accept) begin
            stat_beats_reg <= stat_beats_reg + 32'd1;
            if (tlast_reg) begin
                stat_frames_reg <= stat_frames_reg + 32'd1;
            end
        end
    end

    assign stat_frames = stat_frames_reg;
    assign stat_beats  = stat_beats_reg;
`else
    assign stat_frames = '0;
    assign stat_beats  = '0;
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Randomized bench for fifo_axis_reader: queue-based FIFO and stream reference model.
module tb_fifo_axis_reader;
    localparam int DW = 32;
    localparam int FB = 4;

    logic          rd_clk     = 1'b0;
    logic          rd_rst_n   = 1'b0;
    logic          enable     = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data  = '0;
    logic          fifo_rd_en;
    logic          busy;
    logic [31:0]   stat_frames;
    logic [31:0]   stat_beats;

    fifo_axis_reader_if #(.DATA_WIDTH(DW)) m_axis ();

    fifo_axis_reader #(
        .DATA_WIDTH (DW),
        .FRAME_BEATS(FB)
    ) dut (
        .rd_clk     (rd_clk),
        .rd_rst_n   (rd_rst_n),
        .enable     (enable),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .m_axis     (m_axis),
        .busy       (busy),
        .stat_frames(stat_frames),
        .stat_beats (stat_beats)
    );

    always #5 rd_clk = ~rd_clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] fifo_q[$];   // words still inside the modelled FIFO
    logic [DW-1:0] exp_q[$];    // words the stream is expected to deliver, in order
    int            acc_cnt    = 0;
    int            frames     = 0;
    int            rd_cycles  = 0;
    int            cyc        = 0;
    int            first_acc  = -1;
    int            last_acc   = -1;
    logic          last_rd    = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;
    logic [DW-1:0] next_word  = '0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic push_seq(input int n);
        for (int i = 0; i < n; i++) begin
            push_word(next_word);
            next_word = next_word + 1'b1;
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef FIFO_AXIS_READER_STATS_EN
        check_value({tag, "_stat_beats"}, 64'(stat_beats), 64'(acc_cnt));
        check_value({tag, "_stat_frames"}, 64'(stat_frames), 64'(frames));
`else
        check_value({tag, "_stat_beats"}, 64'(stat_beats), 64'd0);
        check_value({tag, "_stat_frames"}, 64'(stat_frames), 64'd0);
`endif
    endtask

    // One clock cycle: drive at the falling edge, observe around the rising edge.
    task automatic step(input bit ready, input bit en, input bit rst_n);
        logic          rd, acc, v, l;
        logic [DW-1:0] d, e;
        logic          empty_now;
        m_axis.tready = ready;
        enable        = en;
        rd_rst_n      = rst_n;
        empty_now     = (fifo_q.size() == 0);
        fifo_empty    = empty_now;
        fifo_data     = empty_now ? DW'($urandom) : fifo_q[0];
        #1;
        rd      = fifo_rd_en;
        last_rd = rd;
        v       = m_axis.tvalid;
        d       = m_axis.tdata;
        l       = m_axis.tlast;
        acc     = (v === 1'b1) && ready && rst_n;
        check_value("rd_en_while_empty", 64'(rd & empty_now), 64'd0);
        if (prev_stall) begin
            check_value("stall_tvalid_held", 64'(v), 64'd1);
            check_value("stall_tdata_held", 64'(d), 64'(prev_data));
            check_value("stall_tlast_held", 64'(l), 64'(prev_last));
        end
        @(posedge rd_clk);
        #1;
        if (rd && !empty_now) begin
            void'(fifo_q.pop_front());
            rd_cycles++;
        end
        if (!rst_n) begin
            exp_q      = fifo_q;
            acc_cnt    = 0;
            frames     = 0;
            prev_stall = 1'b0;
        end else begin
            if (acc) begin
                if (exp_q.size() == 0) begin
                    check_value("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_value("beat_tdata", 64'(d), 64'(e));
                    check_value("beat_tlast", 64'(l), 64'((acc_cnt % FB) == FB - 1));
                    $display("beat %0d: tdata=0x%0h tlast=%0b cycle=%0d", acc_cnt, d, l, cyc);
                    acc_cnt++;
                    if (l) frames++;
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                end
            end
            prev_stall = (v === 1'b1) && !ready;
            prev_data  = d;
            prev_last  = l;
        end
        cyc++;
        @(negedge rd_clk);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step(1'b1, 1'b0, 1'b1);
            n++;
        end
        if (n >= budget) check_value({tag, "_idle_timeout"}, 64'd1, 64'd0);
    endtask

    initial begin
        int base, fr_base, n, rd_base, pushes;
        m_axis.tready = 1'b0;
        @(negedge rd_clk);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_value("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
        check_value("rst_tlast", 64'(m_axis.tlast), 64'd0);
        check_value("rst_tdata", 64'(m_axis.tdata), 64'd0);
        check_value("rst_busy", 64'(busy), 64'd0);
        check_value("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check_value("rst_tkeep", 64'(m_axis.tkeep), 64'hF);
        check_stats("rst");

        // Back-to-back frames with tready held high.
        push_seq(8);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        check_value("idle_no_pop", 64'(rd_cycles), 64'd0);
        step(1'b1, 1'b1, 1'b1);
        check_value("pop_on_run_entry_edge", 64'(last_rd), 64'd0);
        step(1'b1, 1'b1, 1'b1);
        check_value("first_pop_next_cycle", 64'(last_rd), 64'd1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1);
        check_value("t1_rd_cycles", 64'(rd_cycles), 64'd8);
        check_value("t1_beats", 64'(acc_cnt), 64'd8);
        check_value("t1_contiguous", 64'(last_acc - first_acc), 64'd7);
        check_value("t1_frames", 64'(frames), 64'd2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        check_value("t1_busy_after_stop", 64'(busy), 64'd0);
        check_stats("t1");

        // tready toggling every cycle.
        push_seq(8);
        base = acc_cnt;
        for (int i = 0; i < 30; i++) step(((i % 2) == 0), 1'b1, 1'b1);
        check_value("t2_beats", 64'(acc_cnt - base), 64'd8);
        check_value("t2_fifo_left", 64'(fifo_q.size()), 64'd0);
        wait_idle("t2", 20);

        // Stop request mid-frame drains to the frame end and leaves the rest queued.
        push_seq(10);
        base = acc_cnt;
        n = 0;
        while ((acc_cnt - base) < 6 && n < 40) begin
            step(1'b1, 1'b1, 1'b1);
            n++;
        end
        if (n >= 40) check_value("t3_run_timeout", 64'd1, 64'd0);
        wait_idle("t3", 40);
        check_value("t3_beats", 64'(acc_cnt - base), 64'd8);
        check_value("t3_fifo_left", 64'(fifo_q.size()), 64'd2);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
        check_value("t3_no_pop_idle", 64'(fifo_q.size()), 64'd2);
        check_value("t3_busy", 64'(busy), 64'd0);

        // FIFO runs dry after two beats of a frame, then refills.
        base    = acc_cnt;
        fr_base = frames;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1);
        check_value("t4_gap_tvalid", 64'(m_axis.tvalid), 64'd0);
        check_value("t4_gap_beats", 64'(acc_cnt - base), 64'd2);
        check_value("t4_gap_busy", 64'(busy), 64'd1);
        push_seq(2);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1);
        check_value("t4_beats", 64'(acc_cnt - base), 64'd4);
        check_value("t4_frames", 64'(frames - fr_base), 64'd1);
        check_stats("t4");

        // Reset while a beat is held mid-frame.
        push_seq(6);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check_value("t5_pre_rst_tvalid", 64'(m_axis.tvalid), 64'd1);
        rd_base = rd_cycles;
        step(1'b0, 1'b1, 1'b0);
        check_value("t5_rst_no_pop", 64'(rd_cycles - rd_base), 64'd0);
        check_value("t5_tvalid", 64'(m_axis.tvalid), 64'd0);
        check_value("t5_tlast", 64'(m_axis.tlast), 64'd0);
        check_value("t5_busy", 64'(busy), 64'd0);
        check_stats("t5_rst");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1);
        check_value("t5_beats", 64'(acc_cnt), 64'd4);
        check_value("t5_frames", 64'(frames), 64'd1);
        check_stats("t5");

        // Random tready and bursty FIFO fill.
        pushes = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) < 45 && fifo_q.size() < 16) begin
                push_word(DW'($urandom));
                pushes++;
            end
            step(($urandom_range(0, 99) < 70), 1'b1, 1'b1);
        end
        for (int i = 0; i < FB; i++) push_word(DW'($urandom));
        step(1'b1, 1'b0, 1'b1);
        wait_idle("t6", 200);
        check_value("t6_frame_aligned", 64'(acc_cnt % FB), 64'd0);
        check_value("t6_no_lost_beats", 64'(exp_q.size()), 64'(fifo_q.size()));
        check_value("t6_busy", 64'(busy), 64'd0);
        check_value("t6_frames", 64'(frames), 64'(acc_cnt / FB));
        check_stats("t6");
        $display("random phase pushed %0d words, accepted %0d beats", pushes, acc_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_axis_reader.md
# fifo_axis_reader

Read-side drain engine for the application-template clock-crossing FIFO. Pops words from the FIFO's read port (head word presented combinationally, advanced by a read enable) and emits them as an AXI-Stream master. Frames are cut at a fixed beat count, and a run/stop control takes effect only on frame boundaries. Sits in the read clock domain between the FIFO and the downstream AXI-Stream consumer.

## Interface
- `DATA_WIDTH`, 512, FIFO word and tdata width in bits; multiple of 8
- `FRAME_BEATS`, 16, beats per frame; ≥1; tlast on beat FRAME_BEATS-1
- `rd_clk`  in  1  single clock for the whole block
- `rd_rst_n`  in  1  reset, synchronous to rd_clk, active-low
- `enable`  in  1  run request, sampled at frame boundaries only
- `fifo_data`  in  DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0
- `fifo_empty`  in  1  FIFO empty flag (rd_clk domain)
- `fifo_rd_en`  out  1  pop strobe; FIFO advances on the rd_clk edge where fifo_rd_en=1 and fifo_empty=0
- `m_axis_tdata`  out  DATA_WIDTH  stream data
- `m_axis_tkeep`  out  DATA_WIDTH/8  constant all-ones
- `m_axis_tvalid`  out  1  stream valid
- `m_axis_tready`  in  1  stream ready
- `m_axis_tlast`  out  1  last beat of frame
- `busy`  out  1  high in RUN or DRAIN, or while tvalid=1
- `stat_frames`  out  32  completed-frame counter (see Configuration)
- `stat_beats`  out  32  accepted-beat counter (see Configuration)

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: no pops. `enable`=1 → RUN with beat_cnt=0.
- RUN: `enable`=0 at beat_cnt=0 with no beat pending → IDLE. `enable`=0 mid-frame → DRAIN.
- DRAIN: popping continues until the beat with tlast is accepted, then IDLE. `enable` is ignored in DRAIN.
- Pop condition: `fifo_rd_en = (state≠IDLE) && !fifo_empty && (!m_axis_tvalid || m_axis_tready) && !frame_popped_complete`. The pop is combinational from the current state and flags.
- On a pop edge, fifo_data is registered into tdata, tvalid is set, and tlast = (pop_cnt==FRAME_BEATS-1). pop_cnt width is max(1,$clog2(FRAME_BEATS)) and wraps to 0 after the last pop of a frame.
- `frame_popped_complete` blocks popping the next frame's first beat in DRAIN after the last beat was popped. In RUN, frames run back-to-back.
- tvalid clears on an accept edge (tvalid&tready) with no simultaneous pop. An accept and a pop on the same edge replace the word and keep tvalid=1.
- Once tvalid=1, tdata and tlast are held stable until accepted.
- FIFO empty mid-frame: the frame stalls (tvalid drops after the pending beat is accepted). No timeout and no padding.

## Timing
- Reset values: fifo_rd_en=0, tvalid=0, tlast=0, tdata=0, state=IDLE, pop_cnt=0, busy=0, stat_*=0.
- Reset mid-frame discards the held beat and drops the partial frame. The FIFO is not reset by this block.
- Latency: a word popped on edge N is visible on tdata/tvalid after edge N.
- Throughput: 1 beat/cycle with tready=1 and the FIFO non-empty.
- `enable` rising: first pop occurs in the cycle after the edge where RUN is entered.
- fifo_rd_en is never high while fifo_empty=1 or in IDLE.
- AXI-Stream rule: tvalid never falls without an accept.

## Configuration
- `FIFO_AXIS_READER_STATS_EN` defined:
  - stat_beats increments on every accept edge.
  - stat_frames increments on every accept edge with tlast=1.
  - Both are 32-bit, wrapping, and cleared by reset.
- Undefined: stat_frames and stat_beats are tied to 0 and no counter logic is built.

## Test plan
- FRAME_BEATS=4, FIFO preloaded with 8 words 0..7, enable=1, tready=1 → 8 consecutive beats 0..7; tlast on beats 3 and 7; fifo_rd_en high for exactly 8 cycles.
- Same preload, tready toggling 1/0 every cycle → tdata held through each stall; sequence 0..7 is unchanged; no beat lost or duplicated.
- FRAME_BEATS=4, 10 words loaded, enable dropped after beat 5 is accepted → DRAIN; beats 6,7 emitted with tlast on 7; state returns to IDLE; words 8,9 remain in the FIFO.
- FIFO empties after 2 of 4 beats, refilled 5 cycles later → tvalid low during the gap; tlast asserted on 4th beat overall.
- rd_rst_n low for 1 cycle mid-frame with tvalid=1 → next cycle tvalid=0, tlast=0, state=IDLE; after reset with enable=1, the next popped word carries pop_cnt=0.
- With FIFO_AXIS_READER_STATS_EN, 3 frames of FRAME_BEATS=16 accepted → stat_beats=48, stat_frames=3. Without the macro, both read 0.
